irrigacao_multizona: RTL and testbench
======================================

# irrigacao_multizona

Sequential irrigation controller that generalises the two-area pass-through to N areas sharing one pump. Each area has a low-humidity sensor bit. A round-robin arbiter grants the pump to one dry area at a time. A state machine opens that area's valve for a fixed watering time, then holds a pause so the pump can recover before the next grant. It sits between the humidity sensor inputs and the valve drivers.

## Interface
- `N`, default 4: number of areas/valves; N ≥ 2.
- `T_REGA`, default 8: watering duration in clock cycles; must be ≥ 1.
- `T_PAUSA`, default 4: pump recovery pause in clock cycles; must be ≥ 1.
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: system enable; when low, no new grants and any active watering is aborted.
- `U`  in  N: `U[i]`=1 means area i has low humidity (requests water); `U[i]`=0 means humidity is adequate.
- `S`  out  N: valve drives, registered and one-hot or zero; `S[i]`=1 means area i is being watered.
- `area`  out  $clog2(N): index of the granted area; valid while `busy`=1.
- `busy`  out  1: high in REGA and PAUSA.
- `done`  out  1: one-cycle pulse on the cycle REGA exits (normal end, abort, or early stop).

## Operation
- FSM states are IDLE, REGA and PAUSA. Internal state is a cycle counter `cnt` and a round-robin pointer `ptr`.
- **Reset:** asynchronous.
  - State goes to IDLE.
  - `S`=0, `area`=0, `busy`=0, `done`=0, `cnt`=0, `ptr`=0.
- **IDLE:**
  - If `en`=1 and `U`≠0, the grant goes to the first i with `U[i]`=1, searching `ptr`, `ptr`+1, … mod N.
  - On that edge the next state is REGA, `area`=i, `S`=one-hot(i), `cnt`=0.
  - Otherwise the block stays in IDLE with `S`=0.
- **REGA:**
  - `cnt` increments each cycle.
  - When `cnt`=T_REGA−1, the next state is PAUSA, `S`=0, `done`=1, `cnt`=0, and `ptr`=(`area`+1) mod N.
  - If `en`=0 in any REGA cycle, the same exit happens on that edge (abort).
- **PAUSA:**
  - `S`=0 and `busy`=1.
  - After T_PAUSA cycles, the next state is IDLE.
  - `en` does not shorten the pause.
- **Sensor inputs:**
  - `U` is sampled only in IDLE, at the grant decision.
  - Changes to `U[area]` during REGA are ignored, unless the configuration macro below is defined.
- **Fairness:** a continuously dry area is served within N grants. `ptr` advances past the last served area, including on abort.
- **Arithmetic:**
  - `cnt` is wide enough for max(T_REGA, T_PAUSA); it never wraps.
  - `ptr` and `area` wrap from N−1 to 0.

## Timing
- Grant latency: `S` asserts on the first clock edge where IDLE sees `en`=1 and `U`≠0 (registered, 1 cycle).
- The valve is high for exactly T_REGA cycles. The exception is abort or early stop, which deasserts it on the next edge.
- Minimum spacing between the falling edge of one valve and the rising edge of the next is T_PAUSA+1 cycles (PAUSA plus the IDLE decision cycle).
- `done` coincides with the first PAUSA cycle.
- Reset mid-REGA or mid-PAUSA clears `S` immediately (asynchronously). After `rst_n` is released, a new grant restarts from `ptr`=0.
- If `en` falls and `U[area]` clears on the same edge, that is one exit with one `done`.

## Configuration
- **`IRRIGACAO_EARLY_STOP_EN`**
  - Defined: in REGA, `U[area]`=0 ends watering on that edge. The exit is identical to the normal end: PAUSA, `done`=1, `ptr` advances.
  - Undefined: `U` is ignored during REGA, and watering always lasts T_REGA cycles unless `en` drops.

## Test plan
- **Reset values:** N=4, T_REGA=8, T_PAUSA=4. Hold reset with `U`=4'b1111.
  - Required: `S`=0, `busy`=0, `done`=0.
  - After release with `en`=1: `S`=4'b0001 on the first edge for 8 cycles, then `done` pulses and 4 cycles of PAUSA follow.
- **Round robin:** `U`=4'b1111 held.
  - Required: valves grant in order 0001 → 0010 → 0100 → 1000 → 0001.
  - Each valve-off to valve-on gap is 5 cycles.
- **Pointer skip:** `U`=4'b1001 held.
  - Required: grants alternate area 0, area 3, area 0.
- **Abort:** `en` dropped in the 3rd REGA cycle of area 2.
  - Required: `S`=0 and `done`=1 on the next edge, then 4 PAUSA cycles.
  - The next grant with `U`=4'b0100 is area 2 again, with `ptr` wrapped via 3.
- **Async reset:** `rst_n` pulsed mid-REGA, between clock edges.
  - Required: `S` goes to 0 immediately, not at the next edge, and the FSM returns to IDLE.
- **Early stop:** clear `U[1]` in the 2nd REGA cycle of area 1.
  - With `IRRIGACAO_EARLY_STOP_EN` defined: valve off after 2 cycles, plus a `done` pulse.
  - Without the macro: the valve stays on for the full 8 cycles.

Source files
------------

// File: rtl/irrigacao_multizona.sv
// irrigacao_multizona: N-area irrigation controller sharing one pump.
// A round-robin arbiter picks one dry area, its valve opens for T_REGA
// cycles, then the pump rests for T_PAUSA cycles before the next grant.
// Optional feature macro: IRRIGACAO_EARLY_STOP_EN (a granted area whose
// sensor reports adequate humidity ends its watering early).
module irrigacao_multizona #(
    parameter int N       = 4,
    parameter int T_REGA  = 8,
    parameter int T_PAUSA = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N-1:0]         U,
    output logic [N-1:0]         S,
    output logic [$clog2(N)-1:0] area,
    output logic                 busy,
    output logic                 done
);

    localparam int AW   = $clog2(N);
    localparam int CMAX = (T_REGA > T_PAUSA) ? T_REGA : T_PAUSA;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REGA  = 2'd1,
        PAUSA = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   area_q, area_d;
    logic [N-1:0]    s_q, s_d;
    logic            done_q, done_d;

    logic            grant_found;
    logic [AW-1:0]   grant_idx;
    logic [AW-1:0]   next_area;
    logic            early_stop;

    // Round-robin search: first dry area at or after ptr, wrapping mod N.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N; k++) begin
            int            s;
            logic [AW-1:0] idx;
            s = int'(ptr_q) + k;
            if (s >= N) s = s - N;
            idx = AW'(s);
            if (!grant_found && U[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    assign next_area = (area_q == AW'(N - 1)) ? '0 : area_q + AW'(1);

`ifdef IRRIGACAO_EARLY_STOP_EN
    assign early_stop = ~U[area_q];
`else
    assign early_stop = 1'b0;
`endif

    // Next-state and registered-output logic for IDLE / REGA / PAUSA.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        area_d  = area_q;
        s_d     = s_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                s_d   = '0;
                cnt_d = '0;
                if (en && grant_found) begin
                    state_d = REGA;
                    area_d  = grant_idx;
                    s_d     = N'(1) << grant_idx;
                end
            end
            REGA: begin
                // Normal end, abort and early stop all share one exit path.
                if (!en || early_stop || cnt_q == CW'(T_REGA - 1)) begin
                    state_d = PAUSA;
                    s_d     = '0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    ptr_d   = next_area;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PAUSA: begin
                s_d = '0;
                if (cnt_q == CW'(T_PAUSA - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; async reset clears valves immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            area_q  <= '0;
            s_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            area_q  <= area_d;
            s_q     <= s_d;
            done_q  <= done_d;
        end
    end

    assign S    = s_q;
    assign area = area_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_irrigacao_multizona.sv
// Directed testbench for irrigacao_multizona (N=4, T_REGA=8, T_PAUSA=4).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_irrigacao_multizona;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] U;
    logic [3:0] S;
    logic [1:0] area;
    logic       busy;
    logic       done;

    int tests_run = 0;
    int tests_failed = 0;

    irrigacao_multizona #(.N(4), .T_REGA(8), .T_PAUSA(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .U    (U),
        .S    (S),
        .area (area),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {S, busy, done} packed for compact comparisons.
    function automatic logic [31:0] outs();
        return {26'd0, S, busy, done};
    endfunction

    function automatic logic [31:0] pk(input logic [3:0] s, input logic b, input logic d);
        return {26'd0, s, b, d};
    endfunction

    // One full grant: 8 watering cycles, done pulse, 3 more pause cycles, IDLE.
    task automatic watch_grant(input string tag, input logic [3:0] es, input logic [1:0] ea);
        tick();
        check({tag, " grant"}, outs(), pk(es, 1'b1, 1'b0));
        check({tag, " area"}, {30'd0, area}, {30'd0, ea});
        for (int i = 0; i < 7; i++) begin
            tick();
            check({tag, " hold"}, outs(), pk(es, 1'b1, 1'b0));
        end
        tick();
        check({tag, " done"}, outs(), pk(4'b0000, 1'b1, 1'b1));
        for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, " pause"}, outs(), pk(4'b0000, 1'b1, 1'b0));
        end
        tick();
        check({tag, " idle"}, outs(), pk(4'b0000, 1'b0, 1'b0));
    endtask

    initial begin
        // Reset held with all areas dry.
        rst_n = 1'b0;
        en    = 1'b0;
        U     = 4'b1111;
        repeat (3) tick();
        check("reset outs", outs(), pk(4'b0000, 1'b0, 1'b0));
        check("reset area", {30'd0, area}, 32'd0);

        // Release with enable: first grant is area 0, then round robin.
        rst_n = 1'b1;
        en    = 1'b1;
        watch_grant("rr0", 4'b0001, 2'd0);
        watch_grant("rr1", 4'b0010, 2'd1);
        watch_grant("rr2", 4'b0100, 2'd2);
        watch_grant("rr3", 4'b1000, 2'd3);

        // Pointer skip with only areas 0 and 3 dry (ptr wrapped to 0).
        U = 4'b1001;
        watch_grant("skip0", 4'b0001, 2'd0);
        watch_grant("skip3", 4'b1000, 2'd3);
        watch_grant("skip0b", 4'b0001, 2'd0);

        // Abort: area 2 granted (ptr=1), en drops in its 3rd REGA cycle.
        U = 4'b0100;
        tick();
        check("abort grant", outs(), pk(4'b0100, 1'b1, 1'b0));
        check("abort area", {30'd0, area}, 32'd2);
        tick();
        tick();
        en = 1'b0;
        tick();
        check("abort done", outs(), pk(4'b0000, 1'b1, 1'b1));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort pause", outs(), pk(4'b0000, 1'b1, 1'b0));
        end
        tick();
        check("abort idle", outs(), pk(4'b0000, 1'b0, 1'b0));
        tick();
        check("en low no grant", outs(), pk(4'b0000, 1'b0, 1'b0));
        // ptr is now 3; search 3,0,1,2 finds area 2 again.
        en = 1'b1;
        tick();
        check("regrant area2", outs(), pk(4'b0100, 1'b1, 1'b0));
        check("regrant area", {30'd0, area}, 32'd2);

        // Asynchronous reset between edges during REGA.
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst outs", outs(), pk(4'b0000, 1'b0, 1'b0));
        check("async rst area", {30'd0, area}, 32'd0);
        #2;
        rst_n = 1'b1;
        U     = 4'b1111;
        tick();
        check("post rst grant", outs(), pk(4'b0001, 1'b1, 1'b0));
        check("post rst area", {30'd0, area}, 32'd0);

        // Abort area 0 quickly to move ptr to 1, then grant area 1.
        en = 1'b0;
        tick();
        check("abort0 done", outs(), pk(4'b0000, 1'b1, 1'b1));
        repeat (4) tick();
        check("abort0 idle", outs(), pk(4'b0000, 1'b0, 1'b0));
        en = 1'b1;
        U  = 4'b0010;
        tick();
        check("es grant", outs(), pk(4'b0010, 1'b1, 1'b0));
        tick();
        check("es cycle2", outs(), pk(4'b0010, 1'b1, 1'b0));
        U = 4'b0000;
        tick();
`ifdef IRRIGACAO_EARLY_STOP_EN
        check("es stop done", outs(), pk(4'b0000, 1'b1, 1'b1));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("es pause", outs(), pk(4'b0000, 1'b1, 1'b0));
        end
        tick();
        check("es idle", outs(), pk(4'b0000, 1'b0, 1'b0));
        tick();
        check("es no regrant", outs(), pk(4'b0000, 1'b0, 1'b0));
`else
        check("no es hold", outs(), pk(4'b0010, 1'b1, 1'b0));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no es hold", outs(), pk(4'b0010, 1'b1, 1'b0));
        end
        tick();
        check("no es done", outs(), pk(4'b0000, 1'b1, 1'b1));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
